fifo_ctrl_8x32: RTL

- Synchronous 8-entry x 32-bit FIFO controller. It holds the state, head, tail and data_count registers, the 8-word storage array and the registered read-data port.
- It computes next-state, pointer and count values and feeds them into the 3-bit, 4-bit and 32-bit reset flip-flops.
- It sits between a producer (wr_en/d_in) and a consumer (rd_en/d_out). Status and handshake outputs are decoded from registered state.

---
 rtl/fifo_ctrl_8x32_if.sv | 55 +++++
 rtl/fifo_ctrl_8x32.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_8x32_if.sv
// fifo_ctrl_8x32_if: producer/consumer bundle for the 8x32 FIFO controller.
// master = producer/consumer side, slave = controller; optional almost_* under FIFO_ALMOST_EN.
interface fifo_ctrl_8x32_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [3:0]            data_count;
`ifdef FIFO_ALMOST_EN
  logic                  almost_full;
  logic                  almost_empty;
`endif

`ifdef FIFO_ALMOST_EN
  modport master (
    output rd_en, wr_en, d_in,
    input  d_out, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err,
    input  data_count,
    input  almost_full, almost_empty
  );

  modport slave (
    input  rd_en, wr_en, d_in,
    output d_out, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err,
    output data_count,
    output almost_full, almost_empty
  );
`else
  modport master (
    output rd_en, wr_en, d_in,
    input  d_out, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err,
    input  data_count
  );

  modport slave (
    input  rd_en, wr_en, d_in,
    output d_out, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err,
    output data_count
  );
`endif

endinterface

// File: rtl/fifo_ctrl_8x32.sv
// fifo_ctrl_8x32: 8-entry x 32-bit synchronous FIFO controller with Moore ack/err.
// Ports: clk, reset_n (async active-low), bus (slave: rd_en/wr_en/d_in in; d_out,
// full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count out).
// Macro FIFO_ALMOST_EN adds almost_full (count>=7) and almost_empty (count<=1).
module fifo_ctrl_8x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fifo_ctrl_8x32_if.slave       bus
);

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    NO_OP    = 3'b001,
    WRITE    = 3'b010,
    WR_ERROR = 3'b011,
    READ     = 3'b100,
    RD_ERROR = 3'b101,
    RDWR     = 3'b110
  } state_t;

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t                  state;
  state_t                  state_n;
  logic [ADDR_WIDTH-1:0]   head;
  logic [ADDR_WIDTH-1:0]   head_n;
  logic [ADDR_WIDTH-1:0]   tail;
  logic [ADDR_WIDTH-1:0]   tail_n;
  logic [CW-1:0]           count;
  logic [CW-1:0]           count_n;
  logic [DATA_WIDTH-1:0]   d_out_q;
  logic [DATA_WIDTH-1:0]   d_out_n;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic is_full;
  logic is_empty;
  logic do_wr;
  logic do_rd;

  assign is_full  = (count == CNT_FULL);
  assign is_empty = (count == '0);

  // Next state from inputs and current count only.
  // Simultaneous requests degrade to the single legal action at the limits.
  always_comb begin
    state_n = NO_OP;
    unique case (1'b1)
      (bus.wr_en && !bus.rd_en): begin
        state_n = is_full ? WR_ERROR : WRITE;
      end
      (bus.rd_en && !bus.wr_en): begin
        state_n = is_empty ? RD_ERROR : READ;
      end
      (bus.rd_en && bus.wr_en): begin
        if (is_empty)
          state_n = WRITE;
        else if (is_full)
          state_n = READ;
        else
          state_n = RDWR;
      end
      default: state_n = NO_OP;
    endcase
  end

  // Datapath actions belong to the edge that enters the state.
  assign do_wr = (state_n == WRITE) || (state_n == RDWR);
  assign do_rd = (state_n == READ)  || (state_n == RDWR);

  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    d_out_n = d_out_q;
    if (do_wr)
      tail_n = tail + 1'b1;
    if (do_rd) begin
      head_n  = head + 1'b1;
      d_out_n = mem[head];
    end
    unique case ({do_wr, do_rd})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= INIT;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      d_out_q <= '0;
    end else begin
      state   <= state_n;
      head    <= head_n;
      tail    <= tail_n;
      count   <= count_n;
      d_out_q <= d_out_n;
    end
  end

  // Storage is deliberately not reset; d_out reads the pre-edge
  // contents, so an RDWR on the same slot never forwards d_in.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[tail] <= bus.d_in;
  end

  // Moore decode from registered state and count.
  always_comb begin
    bus.wr_ack = 1'b0;
    bus.rd_ack = 1'b0;
    bus.wr_err = 1'b0;
    bus.rd_err = 1'b0;
    unique case (state)
      WRITE:    bus.wr_ack = 1'b1;
      READ:     bus.rd_ack = 1'b1;
      RDWR: begin
        bus.wr_ack = 1'b1;
        bus.rd_ack = 1'b1;
      end
      WR_ERROR: bus.wr_err = 1'b1;
      RD_ERROR: bus.rd_err = 1'b1;
      default: ;
    endcase
  end

  assign bus.d_out      = d_out_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.data_count = count;

`ifdef FIFO_ALMOST_EN
  assign bus.almost_full  = (count >= CNT_FULL - CNT_ONE);
  assign bus.almost_empty = (count <= CNT_ONE);
`endif

endmodule
